// File: rtl/soc_system_switch_poller.sv
// soc_system_switch_poller
//   Avalon-MM read master that polls a switch PIO (data register at word
//   address 0, fixed read latency, no waitrequest). It keeps the last sampled
//   switch value as a baseline and reports per-bit changes to downstream
//   logic through a valid/ready event stream.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous, active-low reset
//   poll_enable  1 = polling runs, 0 = interval counter cleared and held
//   avm_address  PIO word address (always 0)
//   avm_read     read strobe, one cycle per poll
//   avm_readdata PIO read data, bits [DATA_WIDTH-1:0] used
//   evt_valid    a change event is pending
//   evt_ready    consumer accepts the event
//   evt_data     latest sampled switch value
//   evt_changed  bits that toggled since the last accepted event
module soc_system_switch_poller #(
  parameter int POLL_INTERVAL = 50000,
  parameter int DATA_WIDTH    = 10,
  parameter int READ_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  poll_enable,
  output logic [1:0]            avm_address,
  output logic                  avm_read,
  input  logic [31:0]           avm_readdata,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [DATA_WIDTH-1:0] evt_data,
  output logic [DATA_WIDTH-1:0] evt_changed
);

  localparam int CNT_W  = $clog2(POLL_INTERVAL);
  localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [WAIT_W-1:0]   wait_reg, wait_next;
  logic [DATA_WIDTH-1:0] baseline_reg;
  logic                baseline_valid_reg;

  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] diff;
  logic                  capture;
  logic                  transfer;

  // Upper readdata bits are intentionally ignored.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata;

  assign avm_address = 2'b00;
  assign sample      = avm_readdata[DATA_WIDTH-1:0];
  assign diff        = sample ^ baseline_reg;
  assign capture     = (state_reg == ST_CAPTURE);
  assign transfer    = evt_valid & evt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wait_reg  <= wait_next;
    end
  end

  // The interval counter only advances in IDLE, so the poll period is
  // POLL_INTERVAL plus the ISSUE/WAIT/CAPTURE cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wait_next  = wait_reg;
    avm_read   = 1'b0;
    if (!poll_enable) begin
      cnt_next = '0;
    end
    case (state_reg)
      ST_IDLE: begin
        if (poll_enable) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            state_next = ST_ISSUE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        avm_read  = 1'b1;
        wait_next = '0;
        // With a latency of one, WAIT takes zero cycles and is skipped.
        state_next = (READ_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_reg == WAIT_LAST) begin
          state_next = ST_CAPTURE;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baseline_reg       <= '0;
      baseline_valid_reg <= 1'b0;
      evt_valid          <= 1'b0;
      evt_data           <= '0;
      evt_changed        <= '0;
    end else begin
      if (capture) begin
        baseline_reg       <= sample;
        baseline_valid_reg <= 1'b1;
      end
      if (capture && baseline_valid_reg && (diff != '0)) begin
        // A new change always wins over a simultaneous accept; it is merged
        // only into an event that is still waiting for the consumer.
        evt_valid <= 1'b1;
        evt_data  <= sample;
        if (evt_valid && !transfer) begin
          evt_changed <= evt_changed | diff;
        end else begin
          evt_changed <= diff;
        end
      end else if (transfer) begin
        evt_valid   <= 1'b0;
        evt_changed <= '0;
      end
    end
  end

endmodule
